pipeline_trace_monitor: RTL and testbench

Parametrised, synthesizable run-control and trace monitor that sits beside the RISCVpipeline core in simulation and FPGA bring-up builds. It samples the core's `current_pc`/`instruction` outputs every cycle, records each new fetch into a show-ahead trace FIFO, and counts cycles and fetches. It detects end-of-program (halt instruction or PC stall) and runaway programs (cycle timeout), so benches and debug readout logic no longer rely on fixed-length runs.

---
 rtl/pipeline_trace_monitor.sv | 148 ++++++++++++++
 tb/tb_pipeline_trace_monitor.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_trace_monitor.sv
// Run-control and trace monitor: captures each new PC/instruction fetch into a show-ahead FIFO,
// counts cycles and fetches, and stops on a halt instruction, a PC stall or a cycle timeout.
module pipeline_trace_monitor #(
  parameter int XLEN = 32,
  parameter int DEPTH = 16,
  parameter int STALL_LIMIT = 8,
  parameter int TIMEOUT = 1000,
  parameter logic [XLEN-1:0] HALT_INSTR = XLEN'(32'h00100073),
  parameter int CW = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic [XLEN-1:0]          current_pc,
  input  logic [XLEN-1:0]          instruction,
  input  logic                     rd_en,
  output logic [XLEN-1:0]          rd_pc,
  output logic [XLEN-1:0]          rd_ins,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [CW-1:0]            cycle_count,
  output logic [CW-1:0]            fetch_count,
  output logic                     halted,
  output logic [1:0]               halt_cause,
  output logic                     timed_out
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(STALL_LIMIT + 1);
  localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);
  localparam logic [SW-1:0] STALL_LVL = SW'(STALL_LIMIT);
  localparam logic [CW-1:0] TMO_LVL = CW'(TIMEOUT);

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_HALTED  = 2'd1;
  localparam logic [1:0] ST_TIMEOUT = 2'd2;

  localparam logic [1:0] CAUSE_NONE  = 2'b00;
  localparam logic [1:0] CAUSE_INSTR = 2'b01;
  localparam logic [1:0] CAUSE_STALL = 2'b10;

  logic [1:0]          state;
  logic                first;
  logic [XLEN-1:0]     last_pc;
  logic [SW-1:0]       stall_cnt;
  logic [AW:0]         wr_ptr;
  logic [AW:0]         rd_ptr;
  logic [2*XLEN-1:0]   mem [DEPTH];
  logic [2*XLEN-1:0]   head;

  logic                run;
  logic                fetch;
  logic                pop;
  logic                push;
  logic                drop;
  logic [SW-1:0]       stall_next;
  logic [CW-1:0]       cycle_next;
  logic                halt_instr_hit;
  logic                stall_hit;
  logic                timeout_hit;

  assign level = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (level == FULL_LVL);
  assign head  = mem[rd_ptr[AW-1:0]];
  assign rd_pc  = empty ? '0 : head[2*XLEN-1:XLEN];
  assign rd_ins = empty ? '0 : head[XLEN-1:0];

  assign run   = (state == ST_RUN);
  assign fetch = run && (first || (current_pc != last_pc));
  assign pop   = rd_en && !empty;
  // A pop on the same edge frees a slot, so a fetch into a full FIFO is still accepted.
  assign push  = fetch && (!full || pop);
  assign drop  = fetch && full && !pop;

  assign stall_next     = stall_cnt + SW'(1);
  assign cycle_next     = cycle_count + CW'(1);
  assign halt_instr_hit = fetch && (instruction == HALT_INSTR);
  assign stall_hit      = run && !fetch && (stall_next == STALL_LVL);
  assign timeout_hit    = run && (cycle_next == TMO_LVL);

  assign halted    = (state == ST_HALTED);
  assign timed_out = (state == ST_TIMEOUT);

  always_ff @(posedge clk) begin
    if (push && !clear) begin
      mem[wr_ptr[AW-1:0]] <= {current_pc, instruction};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_RUN;
      first       <= 1'b1;
      last_pc     <= '0;
      stall_cnt   <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      overflow    <= 1'b0;
      cycle_count <= '0;
      fetch_count <= '0;
      halt_cause  <= CAUSE_NONE;
    end else if (clear) begin
      state       <= ST_RUN;
      first       <= 1'b1;
      last_pc     <= '0;
      stall_cnt   <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      overflow    <= 1'b0;
      cycle_count <= '0;
      fetch_count <= '0;
      halt_cause  <= CAUSE_NONE;
    end else begin
      if (pop) begin
        rd_ptr <= rd_ptr + (AW + 1)'(1);
      end
      if (push) begin
        wr_ptr <= wr_ptr + (AW + 1)'(1);
      end
      if (run) begin
        first       <= 1'b0;
        last_pc     <= current_pc;
        cycle_count <= cycle_next;
        stall_cnt   <= fetch ? '0 : stall_next;
        if (fetch) begin
          fetch_count <= fetch_count + CW'(1);
        end
        if (drop) begin
          overflow <= 1'b1;
        end
        // Halt instruction outranks stall, which outranks timeout.
        if (halt_instr_hit) begin
          state      <= ST_HALTED;
          halt_cause <= CAUSE_INSTR;
        end else if (stall_hit) begin
          state      <= ST_HALTED;
          halt_cause <= CAUSE_STALL;
        end else if (timeout_hit) begin
          state <= ST_TIMEOUT;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipeline_trace_monitor.sv
// Bench for pipeline_trace_monitor: directed scenarios plus random stimulus against a queue-based model.
module tb_pipeline_trace_monitor;

  localparam int XLEN = 32;
  localparam int DEPTH = 4;
  localparam int STALL = 8;
  localparam int TMO = 20;
  localparam int CW = 32;
  localparam logic [31:0] HALT = 32'h00100073;

  logic        clk;
  logic        rst;
  logic        clear;
  logic [31:0] current_pc;
  logic [31:0] instruction;
  logic        rd_en;
  logic [31:0] rd_pc;
  logic [31:0] rd_ins;
  logic        empty;
  logic        full;
  logic [2:0]  level;
  logic        overflow;
  logic [31:0] cycle_count;
  logic [31:0] fetch_count;
  logic        halted;
  logic [1:0]  halt_cause;
  logic        timed_out;

  pipeline_trace_monitor #(
    .XLEN(XLEN), .DEPTH(DEPTH), .STALL_LIMIT(STALL), .TIMEOUT(TMO),
    .HALT_INSTR(HALT), .CW(CW)
  ) dut (
    .clk(clk), .rst(rst), .clear(clear), .current_pc(current_pc),
    .instruction(instruction), .rd_en(rd_en), .rd_pc(rd_pc), .rd_ins(rd_ins),
    .empty(empty), .full(full), .level(level), .overflow(overflow),
    .cycle_count(cycle_count), .fetch_count(fetch_count), .halted(halted),
    .halt_cause(halt_cause), .timed_out(timed_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad = 0;

  // Reference model: trace as a queue of {pc, ins}; state 0=run, 1=halted, 2=timeout.
  logic [63:0] mq[$];
  int          m_state;
  bit          m_first;
  logic [31:0] m_last;
  int          m_stall;
  logic [31:0] m_cc;
  logic [31:0] m_fc;
  bit          m_ovf;
  logic [1:0]  m_cause;

  function automatic void m_init();
    mq.delete();
    m_state = 0; m_first = 1; m_last = 0; m_stall = 0;
    m_cc = 0; m_fc = 0; m_ovf = 0; m_cause = 0;
  endfunction

  function automatic void m_edge(input logic c, input logic [31:0] p, input logic [31:0] i, input logic r);
    bit fe;
    if (c) begin
      m_init();
      return;
    end
    if (r && mq.size() > 0) void'(mq.pop_front());
    if (m_state == 0) begin
      fe = m_first || (p != m_last);
      m_cc = m_cc + 1;
      if (fe) begin
        m_fc = m_fc + 1;
        if (mq.size() < DEPTH) mq.push_back({p, i});
        else m_ovf = 1;
        m_stall = 0;
      end else begin
        m_stall = m_stall + 1;
      end
      m_last = p;
      m_first = 0;
      if (fe && i == HALT) begin
        m_state = 1; m_cause = 2'b01;
      end else if (m_stall == STALL) begin
        m_state = 1; m_cause = 2'b10;
      end else if (m_cc == TMO) begin
        m_state = 2;
      end
    end
  endfunction

  task automatic step(input logic c, input logic [31:0] p, input logic [31:0] i, input logic r);
    clear = c; current_pc = p; instruction = i; rd_en = r;
    @(posedge clk);
    m_edge(c, p, i, r);
    #1;
  endtask

  function automatic logic [31:0] rnd_ins();
    logic [31:0] v;
    v = $urandom;
    if (v == HALT) v = 32'h13;
    return v;
  endfunction

  task automatic test_reset();
    rst = 1; clear = 0; current_pc = 0; instruction = 0; rd_en = 0;
    #2;
    total++;
    if (empty !== 1'b1 || full !== 1'b0 || level !== 3'd0 || overflow !== 1'b0) begin
      bad++; $display("FAIL reset_fifo got e=%b f=%b l=%0d o=%b exp e=1 f=0 l=0 o=0", empty, full, level, overflow);
    end
    total++;
    if (cycle_count !== 0 || fetch_count !== 0 || halted !== 1'b0 || halt_cause !== 2'b00 || timed_out !== 1'b0) begin
      bad++; $display("FAIL reset_ctrl got cc=%0d fc=%0d h=%b hc=%b t=%b exp all 0", cycle_count, fetch_count, halted, halt_cause, timed_out);
    end
    total++;
    if (rd_pc !== 0 || rd_ins !== 0) begin
      bad++; $display("FAIL reset_head got pc=%h ins=%h exp 0", rd_pc, rd_ins);
    end
    @(negedge clk);
    rst = 0;
    m_init();
  endtask

  task automatic test_sequence();
    logic [31:0] ins [4];
    step(1, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      ins[k] = rnd_ins();
      step(0, 32'(k * 4), ins[k], 0);
      total++;
      if (level !== 3'(k + 1)) begin
        bad++; $display("FAIL seq_level k=%0d got=%0d exp=%0d", k, level, k + 1);
      end
    end
    total++;
    if (fetch_count !== 4 || full !== 1'b1) begin
      bad++; $display("FAIL seq_fetch got fc=%0d full=%b exp fc=4 full=1", fetch_count, full);
    end
    for (int k = 0; k < 4; k++) begin
      total++;
      if (rd_pc !== 32'(k * 4) || rd_ins !== ins[k]) begin
        bad++; $display("FAIL seq_read k=%0d got %h/%h exp %h/%h", k, rd_pc, rd_ins, k * 4, ins[k]);
      end
      step(0, 32'hC, 32'h13, 1);
    end
    total++;
    if (empty !== 1'b1 || halted !== 1'b0) begin
      bad++; $display("FAIL seq_drain got empty=%b halted=%b exp 1/0", empty, halted);
    end
  endtask

  task automatic test_stall();
    step(1, 0, 0, 0);
    step(0, 32'h10, 32'h13, 0);
    for (int k = 1; k <= 8; k++) begin
      step(0, 32'h10, 32'h13, 0);
      if (k == 7) begin
        total++;
        if (halted !== 1'b0) begin
          bad++; $display("FAIL stall_early got halted=%b exp 0", halted);
        end
      end
    end
    total++;
    if (halted !== 1'b1 || halt_cause !== 2'b10 || cycle_count !== 9) begin
      bad++; $display("FAIL stall_halt got h=%b hc=%b cc=%0d exp 1/10/9", halted, halt_cause, cycle_count);
    end
    for (int k = 0; k < 3; k++) step(0, 32'h40 + 32'(k * 4), 32'h13, 0);
    total++;
    if (cycle_count !== 9 || fetch_count !== 1 || level !== 3'd1) begin
      bad++; $display("FAIL stall_frozen got cc=%0d fc=%0d lvl=%0d exp 9/1/1", cycle_count, fetch_count, level);
    end
  endtask

  task automatic test_halt_instr();
    step(1, 0, 0, 0);
    step(0, 32'h20, HALT, 0);
    total++;
    if (halted !== 1'b1 || halt_cause !== 2'b01 || timed_out !== 1'b0) begin
      bad++; $display("FAIL hinstr_state got h=%b hc=%b t=%b exp 1/01/0", halted, halt_cause, timed_out);
    end
    total++;
    if (level !== 3'd1 || rd_pc !== 32'h20 || rd_ins !== HALT) begin
      bad++; $display("FAIL hinstr_entry got l=%0d %h/%h exp 1 00000020/00100073", level, rd_pc, rd_ins);
    end
  endtask

  task automatic test_overflow();
    step(1, 0, 0, 0);
    for (int k = 0; k < 6; k++) step(0, 32'h100 + 32'(k * 4), 32'h13, 0);
    total++;
    if (full !== 1'b1 || overflow !== 1'b1 || fetch_count !== 6 || level !== 3'd4) begin
      bad++; $display("FAIL ovf_state got f=%b o=%b fc=%0d l=%0d exp 1/1/6/4", full, overflow, fetch_count, level);
    end
    total++;
    if (rd_pc !== 32'h100) begin
      bad++; $display("FAIL ovf_head got=%h exp=00000100", rd_pc);
    end
    step(0, 32'h200, 32'h13, 1);
    total++;
    if (level !== 3'd4 || fetch_count !== 7 || rd_pc !== 32'h104) begin
      bad++; $display("FAIL ovf_pushpop got l=%0d fc=%0d head=%h exp 4/7/00000104", level, fetch_count, rd_pc);
    end
    for (int k = 0; k < 4; k++) begin
      total++;
      if (rd_pc !== ((k < 3) ? 32'h104 + 32'(k * 4) : 32'h200)) begin
        bad++; $display("FAIL ovf_read k=%0d got=%h", k, rd_pc);
      end
      step(0, 32'h200, 32'h13, 1);
    end
    step(0, 32'h200, 32'h13, 1);
    total++;
    if (empty !== 1'b1 || level !== 3'd0 || rd_pc !== 0) begin
      bad++; $display("FAIL ovf_empty_pop got e=%b l=%0d pc=%h exp 1/0/0", empty, level, rd_pc);
    end
  endtask

  task automatic test_timeout();
    step(1, 0, 0, 0);
    for (int k = 1; k <= 20; k++) begin
      step(0, 32'(k * 4), 32'h13, k[0]);
      if (k == 19) begin
        total++;
        if (timed_out !== 1'b0) begin
          bad++; $display("FAIL tmo_early got=%b exp=0", timed_out);
        end
      end
    end
    total++;
    if (timed_out !== 1'b1 || cycle_count !== 20 || halted !== 1'b0) begin
      bad++; $display("FAIL tmo_state got t=%b cc=%0d h=%b exp 1/20/0", timed_out, cycle_count, halted);
    end
    step(1, 32'h500, 32'h13, 0);
    total++;
    if (timed_out !== 1'b0 || cycle_count !== 0 || fetch_count !== 0 || empty !== 1'b1 || overflow !== 1'b0) begin
      bad++; $display("FAIL tmo_clear got t=%b cc=%0d fc=%0d e=%b o=%b exp 0/0/0/1/0", timed_out, cycle_count, fetch_count, empty, overflow);
    end
  endtask

  task automatic test_async_reset();
    step(1, 0, 0, 0);
    for (int k = 0; k < 3; k++) step(0, 32'h300 + 32'(k * 4), 32'h13, 0);
    total++;
    if (level !== 3'd3) begin
      bad++; $display("FAIL areset_pre got=%0d exp=3", level);
    end
    rst = 1;
    #1;
    total++;
    if (empty !== 1'b1 || level !== 3'd0 || fetch_count !== 0 || cycle_count !== 0 || rd_pc !== 0) begin
      bad++; $display("FAIL areset_now got e=%b l=%0d fc=%0d cc=%0d pc=%h exp 1/0/0/0/0", empty, level, fetch_count, cycle_count, rd_pc);
    end
    m_init();
    #1;
    rst = 0;
  endtask

  task automatic test_random();
    logic [31:0] p, i, e_pc, e_ins;
    logic c, r;
    p = 0;
    step(1, 0, 0, 0);
    for (int n = 0; n < 600; n++) begin
      c = ($urandom_range(0, 24) == 0);
      r = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 3) == 0) p = {27'd0, 3'($urandom_range(0, 7)), 2'b00};
      i = ($urandom_range(0, 39) == 0) ? HALT : rnd_ins();
      step(c, p, i, r);
      e_pc  = (mq.size() > 0) ? mq[0][63:32] : 32'd0;
      e_ins = (mq.size() > 0) ? mq[0][31:0] : 32'd0;
      total++;
      if (level !== 3'(mq.size()) || empty !== (mq.size() == 0) || full !== (mq.size() == DEPTH)) begin
        bad++; $display("FAIL rnd_level n=%0d got l=%0d e=%b f=%b exp l=%0d", n, level, empty, full, mq.size());
      end
      total++;
      if (rd_pc !== e_pc || rd_ins !== e_ins) begin
        bad++; $display("FAIL rnd_head n=%0d got %h/%h exp %h/%h", n, rd_pc, rd_ins, e_pc, e_ins);
      end
      total++;
      if (cycle_count !== m_cc || fetch_count !== m_fc || overflow !== m_ovf) begin
        bad++; $display("FAIL rnd_counts n=%0d got cc=%0d fc=%0d o=%b exp cc=%0d fc=%0d o=%b", n, cycle_count, fetch_count, overflow, m_cc, m_fc, m_ovf);
      end
      total++;
      if (halted !== (m_state == 1) || timed_out !== (m_state == 2) || halt_cause !== m_cause) begin
        bad++; $display("FAIL rnd_state n=%0d got h=%b t=%b hc=%b exp st=%0d hc=%b", n, halted, timed_out, halt_cause, m_state, m_cause);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_stall();
    test_halt_instr();
    test_overflow();
    test_timeout();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
